// File: rtl/sa_isa_pkg.sv
// sa_isa_pkg: shared definitions for the instruction-memory interface.
// The host-side writer (inst_writer) and the fetch/decode stage both import it.
// Contents:
//   - instruction field widths and bit positions of the packed word
//   - opcode constants (LD, ST, GEMM, DRAINSYS) and a legality helper
//   - writer FSM state type
//   - FIFO entry layout {word, last, kill}
package sa_isa_pkg;

    localparam int INST_W      = 16;
    localparam int OPCODE_W    = 4;
    localparam int BUF_ID_W    = 2;
    localparam int MEM_LOC_W   = 10;

    localparam int MEM_LOC_LSB = 0;
    localparam int BUF_ID_LSB  = MEM_LOC_LSB + MEM_LOC_W;
    localparam int OPCODE_LSB  = BUF_ID_LSB + BUF_ID_W;

    localparam logic [OPCODE_W-1:0] OP_LD       = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ST       = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_GEMM     = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_DRAINSYS = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [INST_W-1:0] word;
        logic              last;
        logic              kill;
    } inst_entry_t;

    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_GEMM) || (op == OP_DRAINSYS);
    endfunction

endpackage

// File: rtl/inst_wr_fifo.sv
// inst_wr_fifo: synchronous FIFO with registered storage and exact full/empty.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (pointers only)
//   flush          discard all entries (wins over push/pop)
//   push/push_data write one entry when not full
//   pop/pop_data   pop_data shows the head entry; pop removes it when not empty
//   full, empty    exact occupancy flags
module inst_wr_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/inst_writer.sv
// inst_writer: producer side of the instruction-memory interface.
// Accepts {opcode, buf_id, mem_loc, last} over valid/ready, packs each into an
// INST_WIDTH word, buffers it in inst_wr_fifo and writes it to instruction
// memory at consecutive addresses starting from 0.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, clear                  begin a program (IDLE only) / abort to IDLE
//   in_valid/in_ready, in_*       instruction input handshake and fields
//   mem_wr_valid/ready/addr/data  instruction-memory write port
//   prog_done, prog_len           completion flag and words written
//   overflow                      program longer than INST_MEMORY_SIZE
//   err_illegal                   illegal opcode seen
// Build option: define INST_OPCODE_CHECK_EN to drop illegal opcodes (they are
// consumed but never written) and flag err_illegal; otherwise every opcode is
// written verbatim and err_illegal stays 0.
module inst_writer
    import sa_isa_pkg::*;
#(
    parameter int INST_WIDTH       = 16,
    parameter int INST_MEMORY_SIZE = 1024,
    parameter int OPCODE_WIDTH     = 4,
    parameter int BUF_ID_WIDTH     = 2,
    parameter int MEM_LOC_WIDTH    = 10,
    parameter int FIFO_DEPTH       = 4,
    parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [BUF_ID_WIDTH-1:0]  in_buf_id,
    input  logic [MEM_LOC_WIDTH-1:0] in_mem_loc,
    input  logic                     in_last,
    output logic                     mem_wr_valid,
    input  logic                     mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [INST_WIDTH-1:0]    mem_wr_data,
    output logic                     prog_done,
    output logic [ADDR_WIDTH:0]      prog_len,
    output logic                     overflow,
    output logic                     err_illegal
);

    localparam int FIELD_W = OPCODE_WIDTH + BUF_ID_WIDTH + MEM_LOC_WIDTH;
    localparam int ENTRY_W = INST_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] MEM_SIZE = (ADDR_WIDTH + 1)'(INST_MEMORY_SIZE);

    wr_state_t           state_q;
    wr_state_t           state_d;
    logic [ADDR_WIDTH:0] acc_cnt;   // words accepted this program (incl. killed)
    logic [ADDR_WIDTH:0] wr_cnt;    // words written; doubles as write address
    logic                last_acc;
    logic                in_kill;
    logic                push;
    logic                pop;
    logic                wr_fire;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic [INST_WIDTH-1:0] head_word;
    logic                head_last;
    logic                head_kill;

    function automatic logic [INST_WIDTH-1:0] pack_word(
        input logic [OPCODE_WIDTH-1:0]  op,
        input logic [BUF_ID_WIDTH-1:0]  buf_id,
        input logic [MEM_LOC_WIDTH-1:0] loc
    );
        logic [INST_WIDTH-1:0] w;
        w = '0;
        w[FIELD_W-1:0] = {op, buf_id, loc};
        return w;
    endfunction

`ifdef INST_OPCODE_CHECK_EN
    logic err_q;
    assign in_kill     = !is_legal_opcode(OPCODE_W'(in_opcode));
    assign err_illegal = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (clear || (state_q == ST_IDLE && start))
            err_q <= 1'b0;
        else if (push && in_kill)
            err_q <= 1'b1;
    end
`else
    assign in_kill     = 1'b0;
    assign err_illegal = 1'b0;
`endif

    // clear blocks acceptance in the same cycle so nothing lands in a flushed FIFO.
    assign in_ready = (state_q == ST_LOAD) && !fifo_full && !last_acc &&
                      (acc_cnt < MEM_SIZE) && !clear;
    assign push       = in_valid && in_ready;
    assign push_entry = {pack_word(in_opcode, in_buf_id, in_mem_loc), in_last, in_kill};

    inst_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_word, head_last, head_kill} = head_entry;

    // Killed heads are discarded without presenting a write.
    assign mem_wr_valid = (state_q == ST_LOAD) && !fifo_empty && !head_kill;
    assign mem_wr_addr  = wr_cnt[ADDR_WIDTH-1:0];
    assign mem_wr_data  = head_word;
    assign wr_fire      = mem_wr_valid && mem_wr_ready;
    assign pop          = wr_fire || ((state_q == ST_LOAD) && !fifo_empty && head_kill);

    assign prog_done = (state_q == ST_DONE);
    assign overflow  = (state_q == ST_ERR);
    assign prog_len  = wr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (pop && head_last)
                        state_d = ST_DONE;
                    // Overflow is declared only once every accepted word has drained.
                    else if (acc_cnt == MEM_SIZE && !last_acc && fifo_empty)
                        state_d = ST_ERR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            last_acc <= 1'b0;
        end else if (clear) begin
            acc_cnt  <= '0;
            last_acc <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            last_acc <= 1'b0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (in_last)
                    last_acc <= 1'b1;
            end
            if (wr_fire)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_writer.sv
// tb_inst_writer: directed bench for inst_writer with a write monitor that
// records every completed memory write (address, data) in order.
module tb_inst_writer;
    import sa_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [1:0]  in_buf_id;
    logic [9:0]  in_mem_loc;
    logic        in_last;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [9:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        prog_done;
    logic [10:0] prog_len;
    logic        overflow;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wa [$];
    logic [15:0] wd [$];

    inst_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_buf_id    (in_buf_id),
        .in_mem_loc   (in_mem_loc),
        .in_last      (in_last),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .prog_done    (prog_done),
        .prog_len     (prog_len),
        .overflow     (overflow),
        .err_illegal  (err_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_valid && mem_wr_ready) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
        end
    end

    function automatic logic [15:0] pk(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc);
        return {op, b, loc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid   = 1'b1;
        in_opcode  = op;
        in_buf_id  = b;
        in_mem_loc = loc;
        in_last    = last;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_accept observed=0 expected=1");
        end
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (prog_done || overflow) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL wait_end observed=timeout expected=done_or_overflow");
        end
    endtask

    task automatic new_program();
        pulse_clear();
        pulse_start();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_buf_id = '0; in_mem_loc = '0; in_last = 1'b0;
        mem_wr_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_valid", mem_wr_valid, 0);
        chk("rst_prog_done", prog_done, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_illegal", err_illegal, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Basic load
        mem_wr_ready = 1'b1;
        pulse_start();
        wa.delete(); wd.delete();
        send(OP_LD, 2'd1, 10'd5, 1'b0);
        send(OP_GEMM, 2'd0, 10'd0, 1'b0);
        send(OP_DRAINSYS, 2'd0, 10'd0, 1'b1);
        wait_end();
        chk("basic_done", prog_done, 1);
        chk("basic_len", prog_len, 3);
        chk("basic_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("basic_a0", wa[0], 0); chk("basic_d0", wd[0], 16'h2405);
            chk("basic_a1", wa[1], 1); chk("basic_d1", wd[1], 16'h4000);
            chk("basic_a2", wa[2], 2); chk("basic_d2", wd[2], 16'h5000);
        end

        // Backpressure
        mem_wr_ready = 1'b0;
        new_program();
        for (int i = 0; i < 4; i++)
            send((i % 2) ? OP_ST : OP_LD, 2'(i), 10'(i * 7 + 3), 1'b0);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_valid", mem_wr_valid, 1);
        chk("bp_addr", mem_wr_addr, 0);
        chk("bp_data", mem_wr_data, pk(OP_LD, 2'd0, 10'd3));
        repeat (6) @(negedge clk);
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_valid", mem_wr_valid, 1);
        chk("bp_hold_addr", mem_wr_addr, 0);
        chk("bp_hold_data", mem_wr_data, pk(OP_LD, 2'd0, 10'd3));
        chk("bp_no_write", wa.size(), 0);
        mem_wr_ready = 1'b1;
        for (int i = 4; i < 6; i++)
            send((i % 2) ? OP_ST : OP_LD, 2'(i), 10'(i * 7 + 3), i == 5);
        wait_end();
        chk("bp_done", prog_done, 1);
        chk("bp_len", prog_len, 6);
        chk("bp_nwr", wa.size(), 6);
        if (wa.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk("bp_addr_seq", wa[i], i);
                chk("bp_data_seq", wd[i], pk((i % 2) ? OP_ST : OP_LD, 2'(i), 10'(i * 7 + 3)));
            end

        // clear mid-load
        mem_wr_ready = 1'b0;
        new_program();
        send(OP_LD, 2'd2, 10'd9, 1'b0);
        send(OP_ST, 2'd3, 10'd10, 1'b0);
        chk("clr_valid_before", mem_wr_valid, 1);
        pulse_clear();
        chk("clr_valid_after", mem_wr_valid, 0);
        chk("clr_in_ready_after", in_ready, 0);
        chk("clr_done_after", prog_done, 0);
        mem_wr_ready = 1'b1;
        pulse_start();
        wa.delete(); wd.delete();
        send(OP_GEMM, 2'd1, 10'd77, 1'b1);
        wait_end();
        chk("clr_restart_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("clr_restart_addr", wa[0], 0);
            chk("clr_restart_data", wd[0], pk(OP_GEMM, 2'd1, 10'd77));
        end
        chk("clr_restart_len", prog_len, 1);

        // Illegal opcode between two legal words
        new_program();
        send(OP_LD, 2'd1, 10'd1, 1'b0);
        send(4'b1111, 2'd2, 10'd2, 1'b0);
        send(OP_ST, 2'd3, 10'd3, 1'b1);
        wait_end();
        chk("ill_done", prog_done, 1);
`ifdef INST_OPCODE_CHECK_EN
        chk("ill_err", err_illegal, 1);
        chk("ill_len", prog_len, 2);
        chk("ill_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("ill_a0", wa[0], 0); chk("ill_d0", wd[0], 16'h2401);
            chk("ill_a1", wa[1], 1); chk("ill_d1", wd[1], 16'h3C03);
        end
`else
        chk("ill_err", err_illegal, 0);
        chk("ill_len", prog_len, 3);
        chk("ill_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("ill_d0", wd[0], 16'h2401);
            chk("ill_a1", wa[1], 1); chk("ill_d1", wd[1], 16'hF802);
            chk("ill_d2", wd[2], 16'h3C03);
        end
`endif

        // Exact fill: 1024 words, last on the final one
        new_program();
        for (int i = 0; i < 1024; i++)
            send(OP_GEMM, 2'(i), 10'(i), i == 1023);
        wait_end();
        chk("fill_done", prog_done, 1);
        chk("fill_overflow", overflow, 0);
        chk("fill_len", prog_len, 1024);
        chk("fill_nwr", wa.size(), 1024);
        if (wa.size() == 1024) begin
            chk("fill_last_addr", wa[1023], 1023);
            chk("fill_last_data", wd[1023], pk(OP_GEMM, 2'd3, 10'd1023));
            chk("fill_mid_data", wd[513], pk(OP_GEMM, 2'd1, 10'd513));
        end

        // Overflow: 1025 offered words, none last
        new_program();
        for (int i = 0; i < 1024; i++)
            send(OP_LD, 2'd0, 10'(i), 1'b0);
        in_valid = 1'b1; in_opcode = OP_LD; in_mem_loc = 10'd0; in_last = 1'b0;
        chk("ovf_in_ready", in_ready, 0);
        wait_end();
        repeat (3) @(negedge clk);
        chk("ovf_in_ready_err", in_ready, 0);
        in_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_done", prog_done, 0);
        chk("ovf_len", prog_len, 1024);
        chk("ovf_nwr", wa.size(), 1024);
        n0 = 0;
        foreach (wa[i]) if (wa[i] == 10'd0) n0++;
        chk("ovf_addr0_once", n0, 1);
        if (wa.size() == 1024)
            chk("ovf_last_addr", wa[1023], 1023);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_writer.md
Name: inst_writer

Overview:
- Producer end of the instruction-memory interface; the existing fetch/decode stage is the consumer.
- Accepts decoded instruction fields (opcode, buf_id, mem_loc) from the host/compiler over a valid/ready handshake.
- Packs them into INST_WIDTH-bit words, buffers them in a small FIFO, and writes them sequentially from address 0 into instruction memory through a valid/ready write port.
- Reports program length and completion to the fetch stage.

Parameters:
- INST_WIDTH, 16, instruction word width
- INST_MEMORY_SIZE, 1024, instruction memory depth in words
- OPCODE_WIDTH, 4, opcode field width
- BUF_ID_WIDTH, 2, buffer-id field width
- MEM_LOC_WIDTH, 10, memory-location field width
- FIFO_DEPTH, 4, input buffer depth in entries (power of 2, at least 2)
- ADDR_WIDTH, $clog2(INST_MEMORY_SIZE), instruction memory address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin loading a program (honoured in IDLE only)
- clear  in  1  one-cycle pulse: abort/flush, return to IDLE (honoured in any state)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction
- in_opcode  in  OPCODE_WIDTH  opcode
- in_buf_id  in  BUF_ID_WIDTH  buffer id
- in_mem_loc  in  MEM_LOC_WIDTH  memory location
- in_last  in  1  final instruction of the program
- mem_wr_valid  out  1  write request
- mem_wr_ready  in  1  memory accepts write (arbitrated with fetch)
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  INST_WIDTH  packed word
- prog_done  out  1  program fully written (sticky until clear)
- prog_len  out  ADDR_WIDTH+1  number of words written
- overflow  out  1  program exceeded INST_MEMORY_SIZE (sticky until clear)
- err_illegal  out  1  illegal opcode seen (see Optional Feature)

Behaviour:
- Reset, asynchronous: state=IDLE, FIFO empty, wr pointer=0, all outputs 0.
- Packing: mem_wr_data = {opcode, buf_id, mem_loc}, i.e. opcode[15:12], buf_id[11:10], mem_loc[9:0].
  - Bits above OPCODE_WIDTH+BUF_ID_WIDTH+MEM_LOC_WIDTH are zero when INST_WIDTH is larger.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE --start--> LOAD; clears prog_len, pointer, prog_done, overflow, err_illegal.
  - LOAD --write handshake of the entry tagged last--> DONE; prog_done=1 the next cycle.
  - LOAD --accepted count reaches INST_MEMORY_SIZE with in_last=0 on that word--> ERR; overflow=1.
  - DONE/ERR --clear--> IDLE. start outside IDLE is ignored.
- Input handshake: transfer when in_valid && in_ready.
  - in_ready = (state==LOAD) && FIFO not full && last not yet accepted && accepted count < INST_MEMORY_SIZE && !clear.
- Latency: a word accepted at cycle N into an empty FIFO raises mem_wr_valid at N+1 at the earliest.
- Memory handshake: a write completes when mem_wr_valid && mem_wr_ready.
  - mem_wr_valid, addr and data are held stable until that handshake.
  - The pointer increments by 1 per completed write.
- FIFO registered; full and empty are exact. Simultaneous push and pop when full is not allowed because in_ready=0; simultaneous push and pop when non-empty keeps the count unchanged.
- Overflow: the INST_MEMORY_SIZE-th accepted word is still written (addr 1023) and no wrap occurs. The FSM enters ERR only after the FIFO drains.
- The 1024th word with in_last=1 is legal and leads to DONE with prog_len=1024.
- clear mid-operation: the FIFO is flushed, mem_wr_valid drops the next cycle, and any pending write is abandoned. clear has priority over start and over the input handshake in the same cycle.
- prog_len updates on every completed write and is valid as final when prog_done=1.

Optional Feature:
- Macro: INST_OPCODE_CHECK_EN.
- Defined:
  - Opcodes outside {LD=4'b0010, ST=4'b0011, GEMM=4'b0100, DRAINSYS=4'b0101} are still handshaken but marked killed in the FIFO.
  - Killed words are popped without a memory write and without incrementing the pointer or prog_len.
  - err_illegal is set sticky.
  - A killed entry tagged last still completes the program (DONE).
- Not defined: every opcode is packed verbatim; err_illegal is tied to 0.

Decomposition:
- Package sa_isa_pkg holds:
  - field widths and bit indices
  - opcode constants (LD, ST, GEMM, DRAINSYS)
  - the FSM state typedef
  - the FIFO entry struct {word, last, kill}
- The same package is shared with the fetch/decode stage.
- Sub-module inst_wr_fifo: synchronous FIFO, parameterised by width and depth, with push/pop/full/empty/flush.

Test Plan:
- Basic load: start, 3 words (LD buf1 loc5, GEMM, DRAINSYS with last), mem_wr_ready=1 -> writes 0x2405, then 0x4000 and 0x5000 at addr 0..2; prog_done=1, prog_len=3.
- Backpressure: mem_wr_ready=0 for 10 cycles with 6 inputs -> FIFO holds 4 and in_ready=0; data/addr stay stable; after release all 6 words are written in order.
- Overflow: 1025 inputs, none last -> 1024 writes, in_ready drops after the 1024th acceptance, overflow=1, state ERR; no write to addr 0 again.
- Exact fill: 1024 words with the last word tagged last -> prog_done=1, prog_len=1024, overflow=0.
- clear mid-load: clear asserted after 2 of 5 words with mem_wr_ready=0 -> mem_wr_valid=0 the next cycle; after a new start, writes begin again at addr 0.
- Illegal opcode (macro on): opcode 4'b1111 between two legal words -> 2 writes at addr 0..1, err_illegal=1. Macro off: 3 writes, the middle word is 0xF...
